// File: rtl/modport_pkg.sv
// Shared types and constants for the address arbiter slice.
package modport_pkg;

  // Address/data width, matching the 4x8 packed bus fields.
  localparam int unsigned ADDR_W = 32;

  // Largest supported number of address sources.
  localparam int unsigned MAX_SRC = 8;

  // One registered downstream transaction.
  typedef struct packed {
    logic [3:0][7:0] adr;
    logic [3:0][7:0] dat;
    int              sel;
  } t_bus;

  localparam t_bus BUS_RESET = '0;

  // Width of an index able to address n sources (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upwards (modulo NUM_SRC) and grants the
// first requester. Produces a one-hot grant plus its encoded index.
module rr_arbiter
  import modport_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;
  logic             hit;

  // Priority scan starting at ptr; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_SRC);
      if (en && !hit && req[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/modport_addr_arbiter.sv
// Collects addresses from NUM_SRC sources, arbitrates round-robin and presents
// one registered transaction on a packed downstream bus. Also counts accepted
// transfers and flags same-cycle address collisions.
module modport_addr_arbiter
  import modport_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [ADDR_W-1:0]         dat_in,
  output logic [ADDR_W-1:0]         bus_adr,
  output logic [ADDR_W-1:0]         bus_dat,
  output logic signed [31:0]        bus_sel,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic [31:0]               xfer_count,
  output logic                      collision
);

  localparam int unsigned IDX_W = idx_width(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : gen_bad_num_src
    $error("NUM_SRC must be in the range 2..8");
  end

  logic [ADDR_W-1:0] addr_arr [NUM_SRC];

  t_bus             bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [31:0]      count_q, count_d;
  logic             collision_q, collision_d;

  logic             can_load;
  logic             accept;
  logic             coll_now;
  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0] grant_idx;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_unpack
    assign addr_arr[g] = src_addr[g*ADDR_W +: ADDR_W];
  end

  // No grant while in reset so a discarded transaction never sees a ready pulse.
  assign can_load = ~rst & (~valid_q | bus_ready);

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (src_valid),
    .ptr   (ptr_q),
    .en    (can_load),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign src_ready = grant;
  assign accept    = |grant;

  // Any pair of valid sources presenting the same address this cycle.
  always_comb begin
    coll_now = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned j = i + 1; j < NUM_SRC; j++) begin
        if (src_valid[i] && src_valid[j] && (addr_arr[i] == addr_arr[j])) begin
          coll_now = 1'b1;
        end
      end
    end
  end

  // Next state of the output stage, pointer, counter and sticky flag.
  always_comb begin
    bus_d       = bus_q;
    valid_d     = valid_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    collision_d = collision_q | coll_now;
    if (accept) begin
      bus_d.adr = addr_arr[grant_idx];
      bus_d.dat = dat_in;
      bus_d.sel = 32'(grant_idx);
      valid_d   = 1'b1;
      ptr_d     = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      count_d   = count_q + 32'd1;
    end else if (bus_ready) begin
      // Data fields keep their last value; only the valid flag drops.
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q       <= BUS_RESET;
      valid_q     <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      bus_q       <= bus_d;
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      collision_q <= collision_d;
    end
  end

  assign bus_adr    = bus_q.adr;
  assign bus_dat    = bus_q.dat;
  assign bus_sel    = bus_q.sel;
  assign bus_valid  = valid_q;
  assign xfer_count = count_q;
  assign collision  = collision_q;

endmodule

// File: tb/tb_modport_addr_arbiter.sv
// Self-checking bench for modport_addr_arbiter with directed scenarios and a
// randomized run against a transaction-level reference model.
module tb_modport_addr_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*32-1:0]   src_addr;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [31:0]       dat_in;
  logic [31:0]       bus_adr;
  logic [31:0]       bus_dat;
  logic signed [31:0] bus_sel;
  logic              bus_valid;
  logic              bus_ready;
  logic [31:0]       xfer_count;
  logic              collision;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model state.
  logic        m_valid;
  logic [31:0] m_adr, m_dat, m_count;
  int          m_sel, m_ptr;
  logic        m_coll;

  always #5 clk = ~clk;

  modport_addr_arbiter #(
    .NUM_SRC (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_addr   (src_addr),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dat_in     (dat_in),
    .bus_adr    (bus_adr),
    .bus_dat    (bus_dat),
    .bus_sel    (bus_sel),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .xfer_count (xfer_count),
    .collision  (collision)
  );

  function automatic void model_reset();
    m_valid = 1'b0;
    m_adr   = '0;
    m_dat   = '0;
    m_sel   = 0;
    m_ptr   = 0;
    m_count = '0;
    m_coll  = 1'b0;
  endfunction

  // Source the model grants this cycle, or -1.
  function automatic int model_pick();
    if (rst) return -1;
    if (m_valid && !bus_ready) return -1;
    for (int i = 0; i < N; i++) begin
      if (src_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int k;
    k = model_pick();
    return (k >= 0) ? (N'(1) << k) : '0;
  endfunction

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    int   k;
    logic c;
    k = model_pick();
    c = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (src_valid[i] && src_valid[j] && src_addr[i*32 +: 32] == src_addr[j*32 +: 32])
          c = 1'b1;
    @(posedge clk);
    if (k >= 0) begin
      m_valid = 1'b1;
      m_adr   = src_addr[k*32 +: 32];
      m_dat   = dat_in;
      m_sel   = k;
      m_ptr   = (k + 1) % N;
      m_count = m_count + 32'd1;
    end else if (bus_ready) begin
      m_valid = 1'b0;
    end
    if (c) m_coll = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_checks++; if (bus_valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", bus_valid); else n_pass++;
    n_checks++; if (bus_adr !== 32'h0) $display("FAIL rst_adr got %h exp 0", bus_adr); else n_pass++;
    n_checks++; if (bus_dat !== 32'h0) $display("FAIL rst_dat got %h exp 0", bus_dat); else n_pass++;
    n_checks++; if (bus_sel !== 32'sd0) $display("FAIL rst_sel got %0d exp 0", bus_sel); else n_pass++;
    n_checks++; if (xfer_count !== 32'h0) $display("FAIL rst_count got %0d exp 0", xfer_count); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL rst_coll got %0h exp 0", collision); else n_pass++;
    rst = 1'b0;
    model_reset();
    // Load a transaction, hold it with backpressure, then reset mid-cycle.
    src_valid = 2'b01;
    src_addr  = {32'h0, 32'hAAAA5555};
    dat_in    = 32'h0BAD0BAD;
    bus_ready = 1'b0;
    tick();
    n_checks++; if (bus_valid !== 1'b1) $display("FAIL pre_rst_valid got %0h exp 1", bus_valid); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus_valid !== 1'b0) $display("FAIL async_rst_valid got %0h exp 0", bus_valid); else n_pass++;
    n_checks++; if (xfer_count !== 32'h0) $display("FAIL async_rst_count got %0d exp 0", xfer_count); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL async_rst_coll got %0h exp 0", collision); else n_pass++;
    bus_ready = 1'b1;
    #1;
    n_checks++; if (src_ready !== 2'b00) $display("FAIL rst_ready got %b exp 00", src_ready); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_valid = '0;
    model_reset();
  endtask

  task automatic test_single();
    src_valid = 2'b01;
    src_addr  = {32'h0, 32'h12345678};
    dat_in    = 32'hCAFEF00D;
    bus_ready = 1'b1;
    #1;
    n_checks++; if (src_ready !== 2'b01) $display("FAIL single_ready got %b exp 01", src_ready); else n_pass++;
    tick();
    n_checks++; if (bus_adr !== 32'h12345678) $display("FAIL single_adr got %h exp 12345678", bus_adr); else n_pass++;
    n_checks++; if (bus_adr[31:24] !== 8'h12) $display("FAIL single_adr3 got %h exp 12", bus_adr[31:24]); else n_pass++;
    n_checks++; if (bus_dat !== 32'hCAFEF00D) $display("FAIL single_dat got %h exp cafef00d", bus_dat); else n_pass++;
    n_checks++; if (bus_sel !== 32'sd0) $display("FAIL single_sel got %0d exp 0", bus_sel); else n_pass++;
    n_checks++; if (bus_valid !== 1'b1) $display("FAIL single_valid got %0h exp 1", bus_valid); else n_pass++;
    n_checks++; if (xfer_count !== 32'd1) $display("FAIL single_count got %0d exp 1", xfer_count); else n_pass++;
    src_valid = '0;
    tick();
    n_checks++; if (bus_valid !== 1'b0) $display("FAIL drain_valid got %0h exp 0", bus_valid); else n_pass++;
    n_checks++; if (bus_adr !== 32'h12345678) $display("FAIL drain_hold got %h exp 12345678", bus_adr); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_adr;
    do_reset();
    src_valid = 2'b11;
    src_addr  = {32'h20, 32'h10};
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dat_in = 32'(i);
      tick();
      exp_adr = (i % 2 == 1) ? 32'h20 : 32'h10;
      n_checks++; if (bus_sel !== 32'(i % 2)) $display("FAIL rr_sel[%0d] got %0d exp %0d", i, bus_sel, i % 2); else n_pass++;
      n_checks++; if (bus_adr !== exp_adr) $display("FAIL rr_adr[%0d] got %h exp %h", i, bus_adr, exp_adr); else n_pass++;
    end
    n_checks++; if (xfer_count !== 32'd4) $display("FAIL rr_count got %0d exp 4", xfer_count); else n_pass++;
    src_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    src_valid = 2'b01;
    src_addr  = {32'h0, 32'h100};
    dat_in    = 32'h111;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    src_valid = 2'b10;
    dat_in    = 32'h222;
    for (int i = 0; i < 3; i++) begin
      // Address of a waiting source may change; the accept-edge value counts.
      src_addr = {32'h200 + 32'(i), 32'h100};
      #1;
      n_checks++; if (src_ready !== 2'b00) $display("FAIL bp_ready[%0d] got %b exp 00", i, src_ready); else n_pass++;
      tick();
      n_checks++; if (bus_adr !== 32'h100 || bus_dat !== 32'h111 || bus_sel !== 32'sd0 || bus_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got %h/%h/%0d/%0h exp 100/111/0/1", i, bus_adr, bus_dat, bus_sel, bus_valid);
      else n_pass++;
    end
    src_addr  = {32'h2FF, 32'h100};
    bus_ready = 1'b1;
    #1;
    n_checks++; if (src_ready !== 2'b10) $display("FAIL bp_release_ready got %b exp 10", src_ready); else n_pass++;
    tick();
    n_checks++; if (bus_adr !== 32'h2FF) $display("FAIL bp_new_adr got %h exp 2ff", bus_adr); else n_pass++;
    n_checks++; if (bus_dat !== 32'h222) $display("FAIL bp_new_dat got %h exp 222", bus_dat); else n_pass++;
    n_checks++; if (bus_sel !== 32'sd1) $display("FAIL bp_new_sel got %0d exp 1", bus_sel); else n_pass++;
    src_valid = '0;
    tick();
  endtask

  task automatic test_collision();
    n_checks++; if (collision !== 1'b0) $display("FAIL coll_pre got %0h exp 0", collision); else n_pass++;
    src_valid = 2'b11;
    src_addr  = {32'hDEADBEEF, 32'hDEADBEEF};
    bus_ready = 1'b1;
    tick();
    n_checks++; if (collision !== 1'b1) $display("FAIL coll_set got %0h exp 1", collision); else n_pass++;
    src_valid = '0;
    src_addr  = {32'h1, 32'h2};
    tick();
    tick();
    n_checks++; if (collision !== 1'b1) $display("FAIL coll_sticky got %0h exp 1", collision); else n_pass++;
    do_reset();
    n_checks++; if (collision !== 1'b0) $display("FAIL coll_clear got %0h exp 0", collision); else n_pass++;
  endtask

  task automatic test_wrap();
    src_valid = '0;
    bus_ready = 1'b1;
    dut.count_q = 32'hFFFF_FFFF;
    m_count     = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (xfer_count !== 32'hFFFF_FFFF) $display("FAIL wrap_pre got %h exp ffffffff", xfer_count); else n_pass++;
    src_valid = 2'b10;
    src_addr  = {32'h55, 32'h66};
    tick();
    n_checks++; if (xfer_count !== 32'h0) $display("FAIL wrap_count got %h exp 0", xfer_count); else n_pass++;
    src_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0]      pool [4];
    logic [N-1:0]     exp_ready;
    pool[0] = 32'h0000_0010;
    pool[1] = 32'h0000_0020;
    pool[2] = 32'h8000_0004;
    pool[3] = 32'hFFFF_FFFC;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      src_valid = N'($urandom);
      for (int s = 0; s < N; s++) src_addr[s*32 +: 32] = pool[$urandom % 4];
      dat_in    = $urandom;
      bus_ready = ($urandom % 4) != 0;
      #1;
      exp_ready = model_ready();
      n_checks++; if (src_ready !== exp_ready) $display("FAIL rnd_ready[%0d] got %b exp %b", c, src_ready, exp_ready); else n_pass++;
      tick();
      n_checks++; if (bus_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %0h exp %0h", c, bus_valid, m_valid); else n_pass++;
      n_checks++; if (bus_adr !== m_adr || bus_dat !== m_dat || bus_sel !== m_sel)
        $display("FAIL rnd_bus[%0d] got %h/%h/%0d exp %h/%h/%0d", c, bus_adr, bus_dat, bus_sel, m_adr, m_dat, m_sel);
      else n_pass++;
      n_checks++; if (xfer_count !== m_count) $display("FAIL rnd_count[%0d] got %0d exp %0d", c, xfer_count, m_count); else n_pass++;
      n_checks++; if (collision !== m_coll) $display("FAIL rnd_coll[%0d] got %0h exp %0h", c, collision, m_coll); else n_pass++;
    end
    src_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    src_valid = '0;
    src_addr  = '0;
    dat_in    = '0;
    bus_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/modport_addr_arbiter.md
Name: modport_addr_arbiter

Overview:
- Collects 32-bit addresses from NUM_SRC interface sources, each exposing an input-only `addr` (source modport view), plus a per-source valid.
- Arbitrates round-robin and presents one registered transaction on a packed bus: adr (4x8), dat (4x8), sel (int).
- Sits between an array of address-source interfaces and a single downstream bus consumer.
- Also keeps an accepted-transfer count and flags address collisions.

Parameters:
- NUM_SRC, 2, number of address sources; legal range 2..8.
- ADDR_W, 32, address/data width; fixed at 32 to match the 4x8 packed bus fields.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- src_addr  input  NUM_SRC*ADDR_W  concatenated source addresses; source k occupies bits [k*32 +: 32].
- src_valid  input  NUM_SRC  per-source request.
- src_ready  output  NUM_SRC  one-hot grant/accept, combinational.
- dat_in  input  32  data captured alongside the granted address.
- bus_adr  output  32  registered address, viewed as [3:0][7:0].
- bus_dat  output  32  registered data, viewed as [3:0][7:0].
- bus_sel  output  32  signed int; index of the granted source.
- bus_valid  output  1  output register holds a transaction.
- bus_ready  input  1  downstream accepts.
- xfer_count  output  32  accepted source transfers since reset.
- collision  output  1  sticky flag.

Behaviour:
- Reset (async assert, sync release):
  - bus_valid=0, bus_adr=0, bus_dat=0, bus_sel=0, xfer_count=0, collision=0.
  - Round-robin pointer=0.
- Output stage is a single-entry register. It can load when `!bus_valid || bus_ready`, so back-to-back transfers are allowed at 1 per cycle.
- Grant, combinational:
  - Only when the output stage can load.
  - Scan indices ptr, ptr+1, … modulo NUM_SRC; the first with src_valid=1 gets src_ready[k]=1.
  - All other src_ready bits are 0. When the stage cannot load, all are 0.
- Accept (src_valid[k] && src_ready[k]), on the next rising edge:
  - bus_adr<=src_addr[k]; bus_dat<=dat_in; bus_sel<=k; bus_valid<=1.
  - ptr<=(k+1) mod NUM_SRC.
  - xfer_count increments, wrapping 0xFFFFFFFF→0.
  - Latency: one cycle from accept to bus_valid.
- No accept and bus_ready=1 with bus_valid=1: bus_valid<=0. Data fields hold their last value.
- bus_valid=1 and bus_ready=0: all bus fields hold stable. No source is granted.
- Pointer advances only on accept. An idle cycle leaves it unchanged.
- Collision:
  - Set when two or more sources are valid in the same cycle with identical addresses.
  - Evaluated every cycle, independent of grant.
  - Sticky until rst.
- Reset mid-transaction: the pending output is discarded with no ready pulse, and the pointer returns to 0.
- src_addr is sampled only on accept. Values while src_valid=0 are don't-care.
- Changing src_addr while src_valid is high and ungranted is permitted. The value at the accept edge is taken.

Decomposition:
- Shared package modport_pkg holds:
  - typedef t_bus: packed struct {logic [3:0][7:0] adr; logic [3:0][7:0] dat; int sel;}.
  - Constant ADDR_W=32.
  - Constant MAX_SRC=8.
- One sub-module, rr_arbiter: parameterised NUM_SRC, taking req vector, ptr and enable, producing a one-hot grant and an encoded index.
- The top instantiates it once and internally holds bus fields as a t_bus register.

Test Plan:
- Reset: assert rst mid-stream with bus_valid=1 → bus_valid=0, xfer_count=0, collision=0 immediately, before any clk edge.
- Single source:
  - src_valid=01, src_addr[0]=0x12345678, dat_in=0xCAFEF00D, bus_ready=1.
  - Expect src_ready=01; next cycle bus_adr=0x12345678, bus_adr[3]=0x12, bus_dat=0xCAFEF00D, bus_sel=0, bus_valid=1, xfer_count=1.
- Round-robin: both valid continuously, bus_ready=1, distinct addresses 0x10 and 0x20 → bus_sel sequence 0,1,0,1 and bus_adr 0x10,0x20,0x10,0x20; xfer_count=4 after 4 accepts.
- Backpressure:
  - bus_valid=1, bus_ready=0 for 3 cycles while src1 is valid → src_ready=00, bus fields constant.
  - Raise bus_ready → src1 granted the same cycle, new data next cycle.
- Collision: src_valid=11 with src_addr both 0xDEADBEEF for one cycle → collision=1 next cycle and stays 1 after sources idle. Clears only on rst.
- Wrap: force xfer_count to 0xFFFFFFFF (via 2^32-1 accepts in a shortened-width bench, or hierarchical deposit), perform one accept → xfer_count=0.
